// File: rtl/serial_bit_streamer.sv
// -----------------------------------------------------------------------------
// serial_bit_streamer
//
// Feeds a single-bit sequence detector from a parallel word stream. Words are
// accepted on a valid/ready handshake into a small FIFO. A shifter then
// unloads them one bit per clock. When the last bit of a word is consumed and
// another word is waiting, the next word is loaded on that same edge. This
// keeps the serial stream gap-free, so a pattern that straddles two words
// still reaches the detector as one contiguous run of bits.
//
// Parameters:
//   WIDTH      bits per input word (>= 2)
//   DEPTH      FIFO depth in words (power of 2, >= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   in_data     word to serialize
//   in_valid    in_data is valid
//   in_ready    FIFO can accept a word (combinational, = !full)
//   out_ready   downstream consumes the current bit this cycle
//   out_bit     current serial bit (registered)
//   out_valid   out_bit is meaningful (registered)
//   out_last    out_bit is the final bit of its word (registered)
//   fifo_count  words held in the FIFO, not counting the one in the shifter
// -----------------------------------------------------------------------------
module serial_bit_streamer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_bit,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // ------------------------------------------------------------- shifter
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             at_last;

    // Orientation-dependent views of the shifter.
    logic             head_first;   // first bit of the FIFO head word
    logic             next_bit;     // bit presented after one advance
    logic [WIDTH-1:0] shreg_adv;    // shifter contents after one advance

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign fifo_count = count;
    assign head       = mem[rd_ptr];
    assign at_last    = (bit_idx == LAST_IDX);

    // A push never relies on a same-cycle pop to make room: a full FIFO
    // refuses input regardless of what the shifter is doing.
    assign push = in_valid && in_ready;

    // The shifter takes a word either when it is idle or when the bit it is
    // presenting is the last of its word and is being consumed right now.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || (out_ready && at_last));

    // out_bit always reflects bit 0 of the live word in shift order. The
    // shifter is moved towards the output end so that the next bit is at a
    // fixed position.
    always_comb begin
        head_first = 1'b0;
        next_bit   = 1'b0;
        shreg_adv  = shreg;
        if (MSB_FIRST != 0) begin
            head_first = head[WIDTH-1];
            next_bit   = shreg[WIDTH-2];
            shreg_adv  = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            head_first = head[0];
            next_bit   = shreg[1];
            shreg_adv  = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // The storage array has no reset. Stale entries are never read because
    // the pointers and the count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Shifter FSM. All three serial outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Loading does not wait for out_ready. The first bit is
                    // simply presented and held until it is taken.
                    if (pop) begin
                        state     <= SHIFT;
                        shreg     <= head;
                        bit_idx   <= '0;
                        out_bit   <= head_first;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (at_last) begin
                            if (pop) begin
                                // Chain straight into the next word.
                                shreg     <= head;
                                bit_idx   <= '0;
                                out_bit   <= head_first;
                                out_valid <= 1'b1;
                                out_last  <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                shreg     <= '0;
                                bit_idx   <= '0;
                                out_bit   <= 1'b0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            shreg    <= shreg_adv;
                            bit_idx  <= bit_idx + 1'b1;
                            out_bit  <= next_bit;
                            out_last <= ((bit_idx + 1'b1) == LAST_IDX);
                        end
                    end
                    // With out_ready low, every output holds its value.
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed bench for serial_bit_streamer. One instance is MSB-first and the
// other is LSB-first. Both share the clock and the reset.
module tb_serial_bit_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] m_in_data   = '0;
    logic       m_in_valid  = 1'b0;
    logic       m_in_ready;
    logic       m_out_ready = 1'b1;
    logic       m_out_bit;
    logic       m_out_valid;
    logic       m_out_last;
    logic [2:0] m_fifo_count;

    logic [7:0] l_in_data   = '0;
    logic       l_in_valid  = 1'b0;
    logic       l_in_ready;
    logic       l_out_ready = 1'b1;
    logic       l_out_bit;
    logic       l_out_valid;
    logic       l_out_last;
    logic [2:0] l_fifo_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_bit_streamer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst),
        .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_ready(m_out_ready), .out_bit(m_out_bit), .out_valid(m_out_valid),
        .out_last(m_out_last), .fifo_count(m_fifo_count)
    );

    serial_bit_streamer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst),
        .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .out_ready(l_out_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
        .out_last(l_out_last), .fifo_count(l_fifo_count)
    );

    // Advance to just after the next rising edge. Outputs are sampled and
    // inputs are driven from that point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        tick();
        tick();
        tests++;
        if ({m_out_valid, m_out_bit, m_out_last} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outs got=%b want=000", {m_out_valid, m_out_bit, m_out_last});
        end
        tests++;
        if ({m_fifo_count, m_in_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_fifo got cnt=%0d rdy=%b want cnt=0 rdy=1", m_fifo_count, m_in_ready);
        end
        tests++;
        if ({l_out_valid, l_fifo_count, l_in_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL reset_lsb got=%b want=00001", {l_out_valid, l_fifo_count, l_in_ready});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_msb;
        logic [7:0] w;
        w = 8'hDB;
        m_out_ready = 1'b1;
        m_in_data   = w;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid  = 1'b0;
        tests++;
        if ({m_out_valid, m_fifo_count} !== 4'b0001) begin
            fails++;
            $display("FAIL single_accept got v=%b cnt=%0d want v=0 cnt=1", m_out_valid, m_fifo_count);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({m_out_valid, m_out_bit, m_out_last} !== {1'b1, w[7-i], (i == 7)}) begin
                fails++;
                $display("FAIL single_bit%0d got=%b want=%b", i,
                         {m_out_valid, m_out_bit, m_out_last}, {1'b1, w[7-i], (i == 7)});
            end
            tick();
        end
        tests++;
        if ({m_out_valid, m_out_bit, m_out_last} !== 3'b000) begin
            fails++;
            $display("FAIL single_idle got=%b want=000", {m_out_valid, m_out_bit, m_out_last});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        w = 8'hD0;
        m_out_ready = 1'b1;
        m_in_data   = w;
        m_in_valid  = 1'b1;
        tick();
        tick();
        m_in_valid  = 1'b0;
        // The second push coincided with the shifter's pop.
        tests++;
        if (m_fifo_count !== 3'd1) begin
            fails++;
            $display("FAIL b2b_count got=%0d want=1", m_fifo_count);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if ({m_out_valid, m_out_bit, m_out_last} !== {1'b1, w[7-(i%8)], ((i % 8) == 7)}) begin
                fails++;
                $display("FAIL b2b_bit%0d got=%b want=%b", i,
                         {m_out_valid, m_out_bit, m_out_last}, {1'b1, w[7-(i%8)], ((i % 8) == 7)});
            end
            tick();
        end
        tests++;
        if (m_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle got v=%b want v=0", m_out_valid);
        end
    endtask

    task automatic test_stall;
        logic [7:0] w;
        int         idx;
        w = 8'hA5;
        m_out_ready = 1'b1;
        m_in_data   = w;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid  = 1'b0;
        tick();
        // Index shown per valid cycle: 0,1,2,3,4,4,4,4,5,6,7.
        for (int c = 0; c < 11; c++) begin
            idx = (c < 4) ? c : ((c <= 7) ? 4 : c - 3);
            tests++;
            if ({m_out_valid, m_out_bit, m_out_last} !== {1'b1, w[7-idx], (idx == 7)}) begin
                fails++;
                $display("FAIL stall_c%0d got=%b want=%b", c,
                         {m_out_valid, m_out_bit, m_out_last}, {1'b1, w[7-idx], (idx == 7)});
            end
            m_out_ready = !(c >= 4 && c <= 6);
            tick();
        end
        m_out_ready = 1'b1;
        tests++;
        if (m_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle got v=%b want v=0", m_out_valid);
        end
    endtask

    task automatic test_fill_drain;
        logic [7:0] fw [6];
        logic [7:0] w;
        fw = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hFF};
        m_out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            m_in_data  = fw[n];
            m_in_valid = 1'b1;
            tests++;
            if (m_in_ready !== (n < 5)) begin
                fails++;
                $display("FAIL fill_ready%0d got=%b want=%b", n, m_in_ready, (n < 5));
            end
            tick();
        end
        m_in_valid = 1'b0;
        w = fw[0];
        tests++;
        if ({m_fifo_count, m_in_ready, m_out_valid, m_out_bit} !== {3'd4, 1'b0, 1'b1, w[7]}) begin
            fails++;
            $display("FAIL fill_full got cnt=%0d rdy=%b v=%b b=%b want cnt=4 rdy=0 v=1 b=%b",
                     m_fifo_count, m_in_ready, m_out_valid, m_out_bit, w[7]);
        end
        m_out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w = fw[i/8];
            tests++;
            if ({m_out_valid, m_out_bit, m_out_last} !== {1'b1, w[7-(i%8)], ((i % 8) == 7)}) begin
                fails++;
                $display("FAIL drain_bit%0d got=%b want=%b", i,
                         {m_out_valid, m_out_bit, m_out_last}, {1'b1, w[7-(i%8)], ((i % 8) == 7)});
            end
            tick();
        end
        tests++;
        if ({m_out_valid, m_fifo_count, m_in_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL drain_idle got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
                     m_out_valid, m_fifo_count, m_in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rw [3];
        rw = '{8'hF0, 8'h0F, 8'h3C};
        m_out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            m_in_data  = rw[n];
            m_in_valid = 1'b1;
            tick();
        end
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        tick();
        tick();
        tick();
        // Bit index 3 of 8'hF0 in MSB-first order is bit 4, which is 1.
        tests++;
        if ({m_out_valid, m_out_bit, m_fifo_count} !== {1'b1, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL rstmid_pre got v=%b b=%b cnt=%0d want v=1 b=1 cnt=2",
                     m_out_valid, m_out_bit, m_fifo_count);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({m_out_valid, m_out_bit, m_out_last, m_fifo_count, m_in_ready} !== 7'b0000001) begin
            fails++;
            $display("FAIL rstmid_async got v=%b b=%b l=%b cnt=%0d rdy=%b want 0 0 0 0 1",
                     m_out_valid, m_out_bit, m_out_last, m_fifo_count, m_in_ready);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if ({m_out_valid, m_fifo_count} !== 4'b0000) begin
                fails++;
                $display("FAIL rstmid_quiet%0d got v=%b cnt=%0d want v=0 cnt=0", c, m_out_valid, m_fifo_count);
            end
        end
        m_in_data  = 8'h81;
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        tick();
        tests++;
        if ({m_out_valid, m_out_bit, m_out_last} !== 3'b110) begin
            fails++;
            $display("FAIL rstmid_resume got=%b want=110", {m_out_valid, m_out_bit, m_out_last});
        end
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_lsb_first;
        logic [7:0] w;
        w = 8'h0B;
        l_out_ready = 1'b1;
        l_in_data   = w;
        l_in_valid  = 1'b1;
        tick();
        l_in_valid  = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({l_out_valid, l_out_bit, l_out_last} !== {1'b1, w[i], (i == 7)}) begin
                fails++;
                $display("FAIL lsb_bit%0d got=%b want=%b", i,
                         {l_out_valid, l_out_bit, l_out_last}, {1'b1, w[i], (i == 7)});
            end
            tick();
        end
        tests++;
        if ({l_out_valid, l_out_bit} !== 2'b00) begin
            fails++;
            $display("FAIL lsb_idle got=%b want=00", {l_out_valid, l_out_bit});
        end
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_back_to_back();
        test_stall();
        test_fill_drain();
        test_reset_mid();
        test_lsb_first();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_bit_streamer.md
Name: serial_bit_streamer

Overview:
- Upstream feeder for the team's Moore overlapping sequence detectors (e.g. the 1101 detector).
- Accepts parallel words on a valid/ready interface and buffers them in a small FIFO.
- Serializes each word one bit per clock into the detector's single-bit `in` port, with `out_valid` and `out_last` qualifiers.
- Back-to-back words stream with no idle bubble, so overlapping patterns spanning word boundaries stay detectable.

Parameters:
- WIDTH, 8, bits per input word (>=2).
- DEPTH, 4, FIFO depth in words (power of 2, >=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !fifo_full (combinational).
- out_ready  input  1  downstream consumes current bit this cycle.
- out_bit  output  1  current serial bit; drives the detector `in`.
- out_valid  output  1  out_bit is meaningful.
- out_last  output  1  out_bit is the final bit of its word.
- fifo_count  output  $clog2(DEPTH+1)  words held in FIFO, excluding the shifter.

Behaviour:
- Reset (rst=0, async): FIFO pointers/count=0, shifter state=IDLE, bit counter=0, out_bit=0, out_valid=0, out_last=0, fifo_count=0, in_ready=1.
- Push: in_valid && in_ready at a rising edge writes in_data and increments fifo_count. No push while full, even if a pop occurs the same cycle.
- Pop: the shifter loads the FIFO head. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- State machine:
  - IDLE --(fifo_count>0)--> SHIFT: head loaded, bit index=0, out_valid=1 from the next cycle. Loading does not require out_ready.
  - SHIFT, out_ready=0: out_bit, out_valid and out_last are held. No advance.
  - SHIFT, out_ready=1, not last bit: advance to the next bit.
  - SHIFT, out_ready=1, last bit, FIFO non-empty: load the next head the same edge and stay in SHIFT. No bubble.
  - SHIFT, out_ready=1, last bit, FIFO empty: go to IDLE. out_valid=0 and out_bit=0 next cycle.
- Bit order: MSB_FIRST=1 emits bits WIDTH-1 down to 0; MSB_FIRST=0 emits 0 up to WIDTH-1.
- out_last=1 exactly while bit index == WIDTH-1 in SHIFT.
- Latency: a word accepted at edge k into an empty FIFO with the shifter IDLE presents its first bit (out_valid=1) after edge k+1.
- Capacity: DEPTH words in the FIFO plus 1 in the shifter.
- FIFO pointers wrap modulo DEPTH. fifo_count saturates neither way; push is blocked when full and pop is blocked when empty.
- Mid-operation reset: all outputs drop asynchronously. The partial word and the FIFO contents are discarded. After release, streaming resumes only on new pushes.
- Outputs out_bit, out_valid and out_last are registered. in_ready is combinational from the count.

Test Plan:
- Single word 8'hDB, MSB_FIRST=1, out_ready=1 -> out_bit 1,1,0,1,1,0,1,1 on 8 consecutive cycles; out_last on the 8th only; then out_valid=0. With the detector attached, `out` pulses twice (overlap).
- Two words 8'hD0, 8'hD0 pushed back-to-back -> 16 contiguous out_valid cycles, no gap at the boundary, out_last on cycles 8 and 16.
- out_ready=0 for 3 cycles at bit index 4 of 8'hA5 -> out_bit=0 and out_valid=1 held 3 cycles; the remaining bits then follow in order; total 11 valid cycles.
- out_ready=0, push continuously -> 5 words accepted (1 in shifter + DEPTH=4); in_ready=0 after the 5th; fifo_count=4. Raising out_ready drains all 40 bits in order.
- rst=0 at bit 3 of a word with 2 words queued -> out_valid=0 and fifo_count=0 immediately, in_ready=1. After release, no bits are emitted until a new push.
- MSB_FIRST=0, word 8'h0B -> bits 1,1,0,1,0,0,0,0.
